vending_fsm_param: RTL and testbench

//  Parametrised Moore coin-acceptor/vend controller; next generation of the fixed 15-cent coffee FSM.
//  - Accumulates credit from two coin denominations and vends when credit >= PRICE.
//  - Leftover credit is either carried into the next purchase or paid out as change pulses.
//  - Adds cancel/refund and coin rejection while busy.
//  - Sits between the coin-slot decoder and the dispenser/change-hopper drivers.

---
 rtl/vending_pkg.sv | 39 +++
 rtl/change_dispenser.sv | 37 +++
 rtl/vending_fsm_param.sv | 155 +++++++++++++++
 tb/tb_vending_fsm_param.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared state encodings, coin encodings and coin value lookup
//
// Purpose: common definitions for the vend controller and its change dispenser.
// Ports:   none (package).
package vending_pkg;

    // FSM state encodings, kept as plain constants for legacy tool flows.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CREDIT = 3'd1;
    localparam state_t ST_VEND   = 3'd2;
    localparam state_t ST_CHANGE = 3'd3;
    localparam state_t ST_REFUND = 3'd4;

    // Coin-slot decoder encodings.
    localparam logic [1:0] COIN_NONE   = 2'b00;
    localparam logic [1:0] COIN_HI     = 2'b01;
    localparam logic [1:0] COIN_LO     = 2'b10;
    localparam logic [1:0] COIN_CANCEL = 2'b11;

    // Value in cents of the coin presented; cancel and none are worth nothing.
    function automatic int unsigned coin_value(
        input logic [1:0]  coins,
        input int unsigned lo_val,
        input int unsigned hi_val
    );
        case (coins)
            COIN_HI: return hi_val;
            COIN_LO: return lo_val;
            default: return 0;
        endcase
    endfunction

    // True for a real coin (not none, not cancel).
    function automatic logic is_coin(input logic [1:0] coins);
        return (coins == COIN_HI) || (coins == COIN_LO);
    endfunction

endpackage

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - loadable down-counter emitting one pulse per unit of change
//
// Purpose: counts out change/refund units, one per cycle with no gaps.
// Ports:
//   clk    in  1  system clock, rising edge
//   reset  in  1  synchronous, active-high
//   load   in  1  load count (takes priority over counting)
//   count  in  W  number of pulses to emit
//   pulse  out 1  high while units remain (registered count non-zero)
//   done   out 1  high on the cycle the last pulse is being output
module change_dispenser #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] count,
    output logic         pulse,
    output logic         done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= count;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign pulse = (r_cnt != '0);
    assign done  = (r_cnt == W'(1));

endmodule

// File: rtl/vending_fsm_param.sv
// rtl/vending_fsm_param.sv - parametrised Moore coin-acceptor / vend controller
//
// Purpose: accumulates credit from two coin sizes, vends when credit reaches
// PRICE, then carries leftover credit or pays it out as change pulses.
// Cancel refunds accumulated credit; coins offered while busy are rejected.
// Ports:
//   clk          in  1         system clock, rising edge
//   reset        in  1         synchronous, active-high
//   coins        in  2         00 none, 01 large, 10 small, 11 cancel
//   coffee       out 1         dispense strobe (state VEND)
//   change_pulse out 1         one cycle per COIN_LO_VAL returned
//   coin_reject  out 1         registered; coin arrived while busy
//   credit       out CREDIT_W  current credit, cents
//   busy         out 1         high in VEND, CHANGE, REFUND
module vending_fsm_param
    import vending_pkg::*;
#(
    parameter int unsigned PRICE        = 15,
    parameter int unsigned COIN_LO_VAL  = 5,
    parameter int unsigned COIN_HI_VAL  = 10,
    parameter int unsigned VEND_CYCLES  = 1,
    parameter bit          CARRY_CREDIT = 1'b1,
    parameter int unsigned CREDIT_W     = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          coins,
    output logic                coffee,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    // The largest sum ever formed is PRICE-COIN_LO_VAL+COIN_HI_VAL; refuse
    // to build a credit register that could wrap on it.
    if ((2 ** CREDIT_W) <= (PRICE + COIN_HI_VAL)) begin : g_credit_w_check
        $error("vending_fsm_param: CREDIT_W too small for PRICE+COIN_HI_VAL");
    end
    if (VEND_CYCLES < 1) begin : g_vend_cycles_check
        $error("vending_fsm_param: VEND_CYCLES must be >= 1");
    end

    localparam int unsigned          VC_W    = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;
    localparam logic [VC_W-1:0]      VC_LAST = VC_W'(VEND_CYCLES - 1);
    localparam logic [CREDIT_W-1:0]  PRICE_V = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0]  UNIT_V  = CREDIT_W'(COIN_LO_VAL);

    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [VC_W-1:0]     r_vend_cnt;
    logic                r_reject;

    state_t              w_next_state;
    logic [CREDIT_W-1:0] w_next_credit;
    logic [VC_W-1:0]     w_next_vend_cnt;
    logic [CREDIT_W-1:0] w_coin_val;
    logic [CREDIT_W-1:0] w_sum;
    logic [CREDIT_W-1:0] w_units;
    logic                w_load;
    logic                w_pulse;
    logic                w_done;
    logic                w_busy;
    logic                w_paying;

    assign w_coin_val = CREDIT_W'(coin_value(coins, COIN_LO_VAL, COIN_HI_VAL));
    assign w_sum      = r_credit + w_coin_val;
    // Number of change/refund units the current credit is worth.
    assign w_units    = r_credit / UNIT_V;
    assign w_paying   = (r_state == ST_CHANGE) || (r_state == ST_REFUND);
    assign w_busy     = (r_state == ST_VEND) || w_paying;

    always_comb begin
        w_next_state    = r_state;
        w_next_credit   = r_credit;
        w_next_vend_cnt = '0;
        w_load          = 1'b0;
        case (r_state)
            ST_IDLE, ST_CREDIT: begin
                if (is_coin(coins)) begin
                    if (w_sum >= PRICE_V) begin
                        w_next_state  = ST_VEND;
                        w_next_credit = w_sum - PRICE_V;
                    end else begin
                        w_next_state  = ST_CREDIT;
                        w_next_credit = w_sum;
                    end
                end else if ((coins == COIN_CANCEL) && (r_state == ST_CREDIT)) begin
                    w_next_state  = ST_REFUND;
                    w_next_credit = '0;
                    w_load        = 1'b1;
                end
            end
            ST_VEND: begin
                if (r_vend_cnt == VC_LAST) begin
                    if (r_credit == '0) begin
                        w_next_state = ST_IDLE;
                    end else if (CARRY_CREDIT) begin
                        w_next_state = ST_CREDIT;
                    end else begin
                        w_next_state  = ST_CHANGE;
                        w_next_credit = '0;
                        w_load        = 1'b1;
                    end
                end else begin
                    w_next_vend_cnt = r_vend_cnt + VC_W'(1);
                end
            end
            ST_CHANGE, ST_REFUND: begin
                // Leave on the cycle the final pulse is driven; the empty-counter
                // test only guards against a zero-unit load.
                if (w_done || !w_pulse) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state  = ST_IDLE;
                w_next_credit = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_credit   <= '0;
            r_vend_cnt <= '0;
            r_reject   <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_credit   <= w_next_credit;
            r_vend_cnt <= w_next_vend_cnt;
            // Busy states never credit coins; flag each one for exactly a cycle.
            r_reject   <= w_busy && is_coin(coins);
        end
    end

    change_dispenser #(
        .W (CREDIT_W)
    ) u_change_dispenser (
        .clk   (clk),
        .reset (reset),
        .load  (w_load),
        .count (w_units),
        .pulse (w_pulse),
        .done  (w_done)
    );

    assign coffee       = (r_state == ST_VEND);
    assign change_pulse = w_paying && w_pulse;
    assign coin_reject  = r_reject;
    assign credit       = r_credit;
    assign busy         = w_busy;

endmodule

// File: tb/tb_vending_fsm_param.sv
// tb/tb_vending_fsm_param.sv - directed self-checking bench for vending_fsm_param
module tb_vending_fsm_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] coins_a = 2'b00;
    logic [1:0] coins_b = 2'b00;
    logic [1:0] coins_c = 2'b00;

    logic       coffee_a, change_a, reject_a, busy_a;
    logic       coffee_b, change_b, reject_b, busy_b;
    logic       coffee_c, change_c, reject_c, busy_c;
    logic [4:0] credit_a, credit_b, credit_c;

    // Observation words: {coffee, change_pulse, coin_reject, busy, credit[4:0]}
    logic [8:0] obs_a, obs_b, obs_c;
    assign obs_a = {coffee_a, change_a, reject_a, busy_a, credit_a};
    assign obs_b = {coffee_b, change_b, reject_b, busy_b, credit_b};
    assign obs_c = {coffee_c, change_c, reject_c, busy_c, credit_c};

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // A: defaults (carry credit)
    vending_fsm_param u_dut_a (
        .clk(clk), .reset(reset), .coins(coins_a),
        .coffee(coffee_a), .change_pulse(change_a), .coin_reject(reject_a),
        .credit(credit_a), .busy(busy_a)
    );

    // B: leftover paid out as change
    vending_fsm_param #(.CARRY_CREDIT(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .coins(coins_b),
        .coffee(coffee_b), .change_pulse(change_b), .coin_reject(reject_b),
        .credit(credit_b), .busy(busy_b)
    );

    // C: price 20, three-cycle vend, change paid out
    vending_fsm_param #(.PRICE(20), .VEND_CYCLES(3), .CARRY_CREDIT(1'b0)) u_dut_c (
        .clk(clk), .reset(reset), .coins(coins_c),
        .coffee(coffee_c), .change_pulse(change_c), .coin_reject(reject_c),
        .credit(credit_c), .busy(busy_c)
    );

    localparam logic [1:0] NONE = 2'b00, HI = 2'b01, LO = 2'b10, CAN = 2'b11;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        if (obs_a !== 9'b0_0_0_0_00000) begin n_err++; $display("FAIL reset_a got=%b exp=%b", obs_a, 9'b0); end
        n_vec++;
        if (obs_b !== 9'b0_0_0_0_00000) begin n_err++; $display("FAIL reset_b got=%b exp=%b", obs_b, 9'b0); end
        n_vec++;
        if (obs_c !== 9'b0_0_0_0_00000) begin n_err++; $display("FAIL reset_c got=%b exp=%b", obs_c, 9'b0); end
        n_vec++;
        reset = 1'b0;
    endtask

    task automatic test_exact_price();
        logic [1:0] stim [4] = '{LO, HI, NONE, CAN};
        logic [8:0] expv [4] = '{9'b0_0_0_0_00101, 9'b1_0_0_1_00000,
                                 9'b0_0_0_0_00000, 9'b0_0_0_0_00000};
        for (int i = 0; i < 4; i++) begin
            coins_a = stim[i];
            step();
            if (obs_a !== expv[i]) begin n_err++; $display("FAIL exact_price[%0d] got=%b exp=%b", i, obs_a, expv[i]); end
            n_vec++;
        end
        coins_a = NONE;
    endtask

    task automatic test_change_out();
        logic [1:0] stim [4] = '{HI, HI, NONE, NONE};
        logic [8:0] expv [4] = '{9'b0_0_0_0_01010, 9'b1_0_0_1_00101,
                                 9'b0_1_0_1_00000, 9'b0_0_0_0_00000};
        for (int i = 0; i < 4; i++) begin
            coins_b = stim[i];
            step();
            if (obs_b !== expv[i]) begin n_err++; $display("FAIL change_out[%0d] got=%b exp=%b", i, obs_b, expv[i]); end
            n_vec++;
        end
    endtask

    task automatic test_carry_credit();
        logic [1:0] stim [5] = '{HI, HI, NONE, HI, NONE};
        logic [8:0] expv [5] = '{9'b0_0_0_0_01010, 9'b1_0_0_1_00101,
                                 9'b0_0_0_0_00101, 9'b1_0_0_1_00000,
                                 9'b0_0_0_0_00000};
        for (int i = 0; i < 5; i++) begin
            coins_a = stim[i];
            step();
            if (obs_a !== expv[i]) begin n_err++; $display("FAIL carry_credit[%0d] got=%b exp=%b", i, obs_a, expv[i]); end
            n_vec++;
        end
    endtask

    task automatic test_cancel_refund();
        // Cancel in IDLE first (ignored), then a refund of 10 cents.
        logic [1:0] stim [5] = '{CAN, HI, CAN, NONE, NONE};
        logic [8:0] expv [5] = '{9'b0_0_0_0_00000, 9'b0_0_0_0_01010,
                                 9'b0_1_0_1_00000, 9'b0_1_0_1_00000,
                                 9'b0_0_0_0_00000};
        for (int i = 0; i < 5; i++) begin
            coins_a = stim[i];
            step();
            if (obs_a !== expv[i]) begin n_err++; $display("FAIL cancel_refund[%0d] got=%b exp=%b", i, obs_a, expv[i]); end
            n_vec++;
        end
    endtask

    task automatic test_reject_in_vend();
        // VEND spans three cycles; small coin rejected, cancel ignored.
        logic [1:0] stim [6] = '{HI, HI, LO, CAN, NONE, NONE};
        logic [8:0] expv [6] = '{9'b0_0_0_0_01010, 9'b1_0_0_1_00000,
                                 9'b1_0_1_1_00000, 9'b1_0_0_1_00000,
                                 9'b0_0_0_0_00000, 9'b0_0_0_0_00000};
        for (int i = 0; i < 6; i++) begin
            coins_c = stim[i];
            step();
            if (obs_c !== expv[i]) begin n_err++; $display("FAIL reject_in_vend[%0d] got=%b exp=%b", i, obs_c, expv[i]); end
            n_vec++;
        end
    endtask

    task automatic test_back_to_back_reject();
        // Coins in VEND then CHANGE give two consecutive reject cycles.
        logic [1:0] stim [5] = '{HI, HI, LO, HI, NONE};
        logic [8:0] expv [5] = '{9'b0_0_0_0_01010, 9'b1_0_0_1_00101,
                                 9'b0_1_1_1_00000, 9'b0_0_1_0_00000,
                                 9'b0_0_0_0_00000};
        for (int i = 0; i < 5; i++) begin
            coins_b = stim[i];
            step();
            if (obs_b !== expv[i]) begin n_err++; $display("FAIL back_to_back_reject[%0d] got=%b exp=%b", i, obs_b, expv[i]); end
            n_vec++;
        end
    endtask

    task automatic test_reset_mid_refund();
        logic [1:0] stim [3] = '{LO, HI, CAN};
        logic [8:0] expv [3] = '{9'b0_0_0_0_00101, 9'b0_0_0_0_01111,
                                 9'b0_1_0_1_00000};
        for (int i = 0; i < 3; i++) begin
            coins_c = stim[i];
            step();
            if (obs_c !== expv[i]) begin n_err++; $display("FAIL reset_mid_refund[%0d] got=%b exp=%b", i, obs_c, expv[i]); end
            n_vec++;
        end
        coins_c = NONE;
        step();
        if (obs_c !== 9'b0_1_0_1_00000) begin n_err++; $display("FAIL refund_pulse2 got=%b exp=%b", obs_c, 9'b0_1_0_1_00000); end
        n_vec++;
        reset = 1'b1;
        step();
        if (obs_c !== 9'b0) begin n_err++; $display("FAIL reset_mid_refund_clear got=%b exp=%b", obs_c, 9'b0); end
        n_vec++;
        reset = 1'b0;
        step();
        if (obs_c !== 9'b0) begin n_err++; $display("FAIL no_pulse_after_reset got=%b exp=%b", obs_c, 9'b0); end
        n_vec++;
        coins_c = LO;
        step();
        if (obs_c !== 9'b0_0_0_0_00101) begin n_err++; $display("FAIL resume_after_reset got=%b exp=%b", obs_c, 9'b0_0_0_0_00101); end
        n_vec++;
        coins_c = NONE;
    endtask

    initial begin
        test_reset();
        test_exact_price();
        test_change_out();
        test_carry_credit();
        test_cancel_refund();
        test_reject_in_vend();
        test_back_to_back_reject();
        test_reset_mid_refund();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
